crop_controller: RTL and testbench

CROP_CONTROLLER -- requirements
Module: crop_controller

---
 rtl/crop_controller.sv | 186 ++++++++++++++++++
 tb/tb_crop_controller.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crop_controller.sv
// Crop job sequencer.
// Validates a bounding box, runs the header writer and then the cropping
// engine, routes whichever of them is active onto the shared output-memory
// write port, and checks the number of crop writes against the box area.
module crop_controller #(
   parameter int IMG_W   = 100,
   parameter int IMG_H   = 100,
   parameter int TIMEOUT = 1048576
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [10:0] x_min,
   input  logic [10:0] y_min,
   input  logic [10:0] x_max,
   input  logic [10:0] y_max,
   output logic        start_header,
   input  logic        done_header,
   output logic        start_crop,
   input  logic        done_crop,
   input  logic        hdr_wren,
   input  logic [31:0] hdr_addr,
   input  logic [15:0] hdr_wrdata,
   input  logic        crop_wren,
   input  logic [31:0] crop_addr,
   input  logic [15:0] crop_wrdata,
   output logic        mem_wren,
   output logic [31:0] mem_addr,
   output logic [15:0] mem_wrdata,
   output logic        busy,
   output logic        done,
   output logic [1:0]  err,
   output logic [31:0] wr_count
);

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      HDR,
      CROP,
      DONE,
      ERR
   } state_t;

   localparam logic [1:0]  ERR_BOX  = 2'd1;
   localparam logic [1:0]  ERR_TMO  = 2'd2;
   localparam logic [1:0]  ERR_CNT  = 2'd3;
   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

   state_t      state_q;
   logic [10:0] x_min_q, y_min_q, x_max_q, y_max_q;
   logic [23:0] expected_q;
   logic [31:0] tmo_q;
   logic [31:0] wr_count_q;
   logic        start_header_q, start_crop_q, busy_q, done_q;
   logic [1:0]  err_q;

   logic        box_ok;
   logic [11:0] dx, dy;
   logic [23:0] expected_d;
   logic [31:0] wr_count_d;
   logic        tmo_expired;
   logic        count_match;

   // Box validation, area, write count including this cycle's write, and timeout detection
   always_comb begin
      box_ok      = (x_min_q <= x_max_q) && (y_min_q <= y_max_q) &&
                    (32'(x_max_q) < 32'(IMG_W)) && (32'(y_max_q) < 32'(IMG_H));
      dx          = {1'b0, x_max_q} - {1'b0, x_min_q} + 12'd1;
      dy          = {1'b0, y_max_q} - {1'b0, y_min_q} + 12'd1;
      expected_d  = 24'(dx) * 24'(dy);
      wr_count_d  = wr_count_q + 32'(crop_wren);
      tmo_expired = (tmo_q == TMO_LAST);
      count_match = ({8'd0, expected_q} == wr_count_d);
   end

   // Route the active producer's write port onto the output memory; silent otherwise
   always_comb begin
      mem_wren   = 1'b0;
      mem_addr   = '0;
      mem_wrdata = '0;
      if (state_q == HDR) begin
         mem_wren   = hdr_wren;
         mem_addr   = hdr_addr;
         mem_wrdata = hdr_wrdata;
      end else if (state_q == CROP) begin
         mem_wren   = crop_wren;
         mem_addr   = crop_addr;
         mem_wrdata = crop_wrdata;
      end
   end

   // Job sequencer with registered status outputs and one-cycle start pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         x_min_q        <= '0;
         y_min_q        <= '0;
         x_max_q        <= '0;
         y_max_q        <= '0;
         expected_q     <= '0;
         tmo_q          <= '0;
         wr_count_q     <= '0;
         start_header_q <= 1'b0;
         start_crop_q   <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         err_q          <= '0;
      end else begin
         start_header_q <= 1'b0;
         start_crop_q   <= 1'b0;
         case (state_q)
            IDLE, DONE, ERR: begin
               if (start) begin
                  x_min_q    <= x_min;
                  y_min_q    <= y_min;
                  x_max_q    <= x_max;
                  y_max_q    <= y_max;
                  done_q     <= 1'b0;
                  err_q      <= '0;
                  wr_count_q <= '0;
                  tmo_q      <= '0;
                  busy_q     <= 1'b1;
                  state_q    <= CHECK;
               end
            end
            CHECK: begin
               if (box_ok) begin
                  expected_q     <= expected_d;
                  tmo_q          <= '0;
                  start_header_q <= 1'b1;
                  state_q        <= HDR;
               end else begin
                  err_q   <= ERR_BOX;
                  busy_q  <= 1'b0;
                  state_q <= ERR;
               end
            end
            HDR: begin
               if (done_header) begin
                  tmo_q        <= '0;
                  start_crop_q <= 1'b1;
                  state_q      <= CROP;
               end else if (tmo_expired) begin
                  err_q   <= ERR_TMO;
                  busy_q  <= 1'b0;
                  state_q <= ERR;
               end else begin
                  tmo_q <= tmo_q + 32'd1;
               end
            end
            CROP: begin
               wr_count_q <= wr_count_d;
               if (done_crop) begin
                  busy_q <= 1'b0;
                  if (count_match) begin
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     err_q   <= ERR_CNT;
                     state_q <= ERR;
                  end
               end else if (tmo_expired) begin
                  err_q   <= ERR_TMO;
                  busy_q  <= 1'b0;
                  state_q <= ERR;
               end else begin
                  tmo_q <= tmo_q + 32'd1;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign start_header = start_header_q;
   assign start_crop   = start_crop_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign err          = err_q;
   assign wr_count     = wr_count_q;

endmodule

// File: tb/tb_crop_controller.sv
// Bench for crop_controller: two instances (default timeout and a short
// timeout of 16) share one stimulus stream and are compared every cycle
// against a job-level reference model, plus hand-computed spot checks.
module tb_crop_controller;

   localparam int TMO_B   = 16;
   localparam int P_IDLE  = 0;
   localparam int P_CHECK = 1;
   localparam int P_HDR   = 2;
   localparam int P_CROP  = 3;
   localparam int P_DONE  = 4;
   localparam int P_ERR   = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [10:0] xMin, yMin, xMax, yMax;
   logic        doneHeader, doneCrop, hdrWren, cropWren;
   logic [31:0] hdrAddr, cropAddr;
   logic [15:0] hdrData, cropData;

   logic        shO    [2];
   logic        scO    [2];
   logic        mwrenO [2];
   logic [31:0] maddrO [2];
   logic [15:0] mdataO [2];
   logic        busyO  [2];
   logic        doneO  [2];
   logic [1:0]  errO   [2];
   logic [31:0] wrO    [2];

   int nChecks = 0;
   int nFail   = 0;
   int memCountA = 0;
   int shCountA  = 0;
   int scCountA  = 0;

   // Reference model state per instance
   int ph  [2];
   int age [2];
   int cnt [2];
   int px  [2];
   int bx0 [2];
   int by0 [2];
   int bx1 [2];
   int by1 [2];
   int mErr [2];
   bit mDone [2];

   always #5 clk = ~clk;

   crop_controller dutA (
      .clk(clk), .rst(rst), .start(start),
      .x_min(xMin), .y_min(yMin), .x_max(xMax), .y_max(yMax),
      .start_header(shO[0]), .done_header(doneHeader),
      .start_crop(scO[0]), .done_crop(doneCrop),
      .hdr_wren(hdrWren), .hdr_addr(hdrAddr), .hdr_wrdata(hdrData),
      .crop_wren(cropWren), .crop_addr(cropAddr), .crop_wrdata(cropData),
      .mem_wren(mwrenO[0]), .mem_addr(maddrO[0]), .mem_wrdata(mdataO[0]),
      .busy(busyO[0]), .done(doneO[0]), .err(errO[0]), .wr_count(wrO[0])
   );

   crop_controller #(.TIMEOUT(TMO_B)) dutB (
      .clk(clk), .rst(rst), .start(start),
      .x_min(xMin), .y_min(yMin), .x_max(xMax), .y_max(yMax),
      .start_header(shO[1]), .done_header(doneHeader),
      .start_crop(scO[1]), .done_crop(doneCrop),
      .hdr_wren(hdrWren), .hdr_addr(hdrAddr), .hdr_wrdata(hdrData),
      .crop_wren(cropWren), .crop_addr(cropAddr), .crop_wrdata(cropData),
      .mem_wren(mwrenO[1]), .mem_addr(maddrO[1]), .mem_wrdata(mdataO[1]),
      .busy(busyO[1]), .done(doneO[1]), .err(errO[1]), .wr_count(wrO[1])
   );

   function automatic int tmoOf(input int i);
      return (i == 0) ? 1048576 : TMO_B;
   endfunction

   function automatic bit boxOk(input int a, input int b, input int c, input int d);
      return (a <= c) && (b <= d) && (c < 100) && (d < 100);
   endfunction

   // Job-level reference: age is the 1-based cycle number within HDR/CROP
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            ph[i] <= P_IDLE; age[i] <= 0; cnt[i] <= 0; px[i] <= 0;
            bx0[i] <= 0; by0[i] <= 0; bx1[i] <= 0; by1[i] <= 0;
            mErr[i] <= 0; mDone[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            case (ph[i])
               P_IDLE, P_DONE, P_ERR: if (start) begin
                  bx0[i] <= int'(xMin); by0[i] <= int'(yMin);
                  bx1[i] <= int'(xMax); by1[i] <= int'(yMax);
                  mDone[i] <= 1'b0; mErr[i] <= 0; cnt[i] <= 0;
                  ph[i] <= P_CHECK;
               end
               P_CHECK: if (boxOk(bx0[i], by0[i], bx1[i], by1[i])) begin
                  px[i]  <= (bx1[i] - bx0[i] + 1) * (by1[i] - by0[i] + 1);
                  ph[i]  <= P_HDR;
                  age[i] <= 1;
               end else begin
                  ph[i] <= P_ERR; mErr[i] <= 1;
               end
               P_HDR: if (doneHeader) begin
                  ph[i] <= P_CROP; age[i] <= 1;
               end else if (age[i] == tmoOf(i)) begin
                  ph[i] <= P_ERR; mErr[i] <= 2;
               end else begin
                  age[i] <= age[i] + 1;
               end
               P_CROP: begin
                  cnt[i] <= cnt[i] + int'(cropWren);
                  if (doneCrop) begin
                     if (cnt[i] + int'(cropWren) == px[i]) begin
                        ph[i] <= P_DONE; mDone[i] <= 1'b1;
                     end else begin
                        ph[i] <= P_ERR; mErr[i] <= 3;
                     end
                  end else if (age[i] == tmoOf(i)) begin
                     ph[i] <= P_ERR; mErr[i] <= 2;
                  end else begin
                     age[i] <= age[i] + 1;
                  end
               end
               default: ph[i] <= P_IDLE;
            endcase
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of both instances against the model
   initial begin
      logic  eb, esh, esc, ew;
      string n;
      forever begin
         @(negedge clk);
         #2;
         if (mwrenO[0]) memCountA++;
         if (shO[0]) shCountA++;
         if (scO[0]) scCountA++;
         for (int i = 0; i < 2; i++) begin
            n   = (i == 0) ? "A" : "B";
            eb  = (ph[i] == P_CHECK) || (ph[i] == P_HDR) || (ph[i] == P_CROP);
            esh = (ph[i] == P_HDR) && (age[i] == 1);
            esc = (ph[i] == P_CROP) && (age[i] == 1);
            ew  = ((ph[i] == P_HDR) && hdrWren) || ((ph[i] == P_CROP) && cropWren);
            checkOutput({n, " busy"}, 32'(busyO[i]), 32'(eb));
            checkOutput({n, " done"}, 32'(doneO[i]), 32'(mDone[i]));
            checkOutput({n, " err"}, 32'(errO[i]), 32'(mErr[i]));
            checkOutput({n, " wr_count"}, wrO[i], 32'(cnt[i]));
            checkOutput({n, " start_header"}, 32'(shO[i]), 32'(esh));
            checkOutput({n, " start_crop"}, 32'(scO[i]), 32'(esc));
            checkOutput({n, " mem_wren"}, 32'(mwrenO[i]), 32'(ew));
            if (ew) begin
               checkOutput({n, " mem_addr"}, maddrO[i], (ph[i] == P_HDR) ? hdrAddr : cropAddr);
               checkOutput({n, " mem_wrdata"}, 32'(mdataO[i]),
                           32'((ph[i] == P_HDR) ? hdrData : cropData));
            end
         end
      end
   end

   task automatic setIdle();
      hdrWren = 1'b0; cropWren = 1'b0; doneHeader = 1'b0; doneCrop = 1'b0;
      hdrAddr = '0; cropAddr = '0; hdrData = '0; cropData = '0;
   endtask

   task automatic resetCheck();
      for (int i = 0; i < 2; i++) begin
         checkOutput("rst busy", 32'(busyO[i]), 0);
         checkOutput("rst done", 32'(doneO[i]), 0);
         checkOutput("rst err", 32'(errO[i]), 0);
         checkOutput("rst wr_count", wrO[i], 0);
         checkOutput("rst start_header", 32'(shO[i]), 0);
         checkOutput("rst start_crop", 32'(scO[i]), 0);
         checkOutput("rst mem_wren", 32'(mwrenO[i]), 0);
      end
   endtask

   // Asynchronous reset pulse with producers still active, then confirm silence
   task automatic doReset();
      int mb, pb;
      @(negedge clk);
      hdrWren = 1'b1; cropWren = 1'b1; doneHeader = 1'b1; doneCrop = 1'b1;
      #3 rst = 1'b1;
      @(negedge clk);
      #1 resetCheck();
      @(negedge clk);
      rst = 1'b0;
      mb = memCountA;
      pb = shCountA + scCountA;
      repeat (3) @(negedge clk);
      setIdle();
      #3;
      checkOutput("post-reset writes", 32'(memCountA - mb), 0);
      checkOutput("post-reset pulses", 32'(shCountA + scCountA - pb), 0);
   endtask

   task automatic startJob(input int a, input int b, input int c, input int d);
      @(negedge clk);
      xMin = 11'(a); yMin = 11'(b); xMax = 11'(c); yMax = 11'(d);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      xMin = 11'h7ff; yMin = 11'h7ff; xMax = 11'h7ff; yMax = 11'h7ff;
   endtask

   // Runs one job, following the handshake of instance 'who'
   task automatic applyStimulus(input int who, input int a, input int b, input int c, input int d,
                                input int nHdr, input bit hdrDone, input int nCrop,
                                input bit cropDone, input bit gaps, input int abortAt);
      int k, j, cyc;
      startJob(a, b, c, d);
      k = 0;
      while (!shO[who] && k < 4) begin @(negedge clk); k++; end
      if (!shO[who]) begin checkOutput("wait start_header", 32'(shO[who]), 1); return; end
      for (int h = 0; h < nHdr; h++) begin
         hdrWren = 1'b1; hdrAddr = 32'h1000 + 32'(h); hdrData = 16'(h * 3 + 1);
         cropWren = 1'b1; cropAddr = 32'hdead; cropData = 16'hbeef;
         doneHeader = hdrDone && (h == nHdr - 1);
         @(negedge clk);
      end
      if (nHdr == 0 && hdrDone) begin setIdle(); doneHeader = 1'b1; @(negedge clk); end
      setIdle();
      if (!hdrDone) return;
      k = 0;
      while (!scO[who] && k < 4) begin @(negedge clk); k++; end
      if (!scO[who]) begin checkOutput("wait start_crop", 32'(scO[who]), 1); return; end
      j = 0;
      cyc = 0;
      while (j < nCrop) begin
         if (abortAt >= 0 && j == abortAt) begin start = 1'b0; doReset(); return; end
         start   = (cyc == 3);
         hdrWren = (cyc % 5 == 0); hdrAddr = 32'hbad0_0000 + 32'(cyc); hdrData = 16'hbad1;
         if (gaps && (cyc % 97 == 50)) begin
            cropWren = 1'b0; doneCrop = 1'b0;
         end else begin
            cropWren = 1'b1; cropAddr = 32'h2000 + 32'(j); cropData = 16'(j) ^ 16'h5a5a;
            doneCrop = cropDone && (j == nCrop - 1);
            j++;
         end
         cyc++;
         @(negedge clk);
      end
      start = 1'b0;
      if (nCrop == 0 && cropDone) begin setIdle(); doneCrop = 1'b1; @(negedge clk); end
      setIdle();
      repeat (3) @(negedge clk);
      #1;
   endtask

   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int mb, sb, cb;
      rst = 1'b1;
      start = 1'b0;
      xMin = '0; yMin = '0; xMax = '0; yMax = '0;
      setIdle();
      repeat (3) @(negedge clk);
      #1 resetCheck();
      @(negedge clk);
      rst = 1'b0;

      // Full job: 42x45 box, 3 header writes, 1890 crop writes
      mb = memCountA; sb = shCountA; cb = scCountA;
      applyStimulus(0, 28, 34, 69, 78, 3, 1'b1, 1890, 1'b1, 1'b1, -1);
      checkOutput("job1 done", 32'(doneO[0]), 1);
      checkOutput("job1 err", 32'(errO[0]), 0);
      checkOutput("job1 wr_count", wrO[0], 1890);
      checkOutput("job1 mem writes", 32'(memCountA - mb), 1893);
      checkOutput("job1 start_header pulses", 32'(shCountA - sb), 1);
      checkOutput("job1 start_crop pulses", 32'(scCountA - cb), 1);
      checkOutput("job1 short-timeout err", 32'(errO[1]), 2);

      // Inverted box: error two cycles after start, no header pulse, no writes
      mb = memCountA; sb = shCountA;
      hdrWren = 1'b1; hdrAddr = 32'h77; hdrData = 16'h77;
      startJob(50, 10, 40, 20);
      #1;
      checkOutput("badbox busy in check", 32'(busyO[0]), 1);
      checkOutput("badbox err in check", 32'(errO[0]), 0);
      @(negedge clk);
      #1;
      checkOutput("badbox err", 32'(errO[0]), 1);
      checkOutput("badbox busy", 32'(busyO[0]), 0);
      repeat (3) @(negedge clk);
      setIdle();
      #3;
      checkOutput("badbox mem writes", 32'(memCountA - mb), 0);
      checkOutput("badbox start_header pulses", 32'(shCountA - sb), 0);

      // Height boundary: y_max == IMG_H rejected, full image accepted
      startJob(0, 0, 99, 100);
      repeat (2) @(negedge clk);
      #1 checkOutput("ymax=IMG_H err", 32'(errO[0]), 1);
      applyStimulus(0, 0, 0, 99, 99, 2, 1'b1, 10000, 1'b1, 1'b1, -1);
      checkOutput("full image done", 32'(doneO[0]), 1);
      checkOutput("full image wr_count", wrO[0], 10000);
      checkOutput("full image err", 32'(errO[0]), 0);

      // Single-pixel box with no crop writes: count mismatch
      applyStimulus(0, 5, 5, 5, 5, 1, 1'b1, 0, 1'b1, 1'b0, -1);
      checkOutput("empty crop err", 32'(errO[0]), 3);

      // One write short of the area
      applyStimulus(0, 28, 34, 69, 78, 3, 1'b1, 1889, 1'b1, 1'b1, -1);
      checkOutput("short job err", 32'(errO[0]), 3);
      checkOutput("short job done", 32'(doneO[0]), 0);
      checkOutput("short job wr_count", wrO[0], 1889);

      // Header never completes: short-timeout instance errors after its 16th HDR cycle
      applyStimulus(1, 0, 0, 3, 3, 0, 1'b0, 0, 1'b0, 1'b0, -1);
      repeat (15) @(negedge clk);
      #1;
      checkOutput("hdr tmo cycle16 err", 32'(errO[1]), 0);
      checkOutput("hdr tmo cycle16 busy", 32'(busyO[1]), 1);
      @(negedge clk);
      #1;
      checkOutput("hdr tmo err", 32'(errO[1]), 2);
      checkOutput("hdr tmo busy", 32'(busyO[1]), 0);
      doReset();

      // Completions on the last allowed cycle of HDR and CROP win over timeout
      applyStimulus(1, 0, 0, 3, 3, 16, 1'b1, 16, 1'b1, 1'b0, -1);
      checkOutput("edge done B", 32'(doneO[1]), 1);
      checkOutput("edge err B", 32'(errO[1]), 0);
      checkOutput("edge wr_count B", wrO[1], 16);

      // One cycle too many in CROP times out the short instance
      applyStimulus(1, 0, 0, 16, 0, 16, 1'b1, 17, 1'b1, 1'b0, -1);
      checkOutput("late done B err", 32'(errO[1]), 2);
      checkOutput("late done B wr_count", wrO[1], 16);
      checkOutput("late done A done", 32'(doneO[0]), 1);

      // Reset in the middle of CROP, then a fresh job
      applyStimulus(0, 28, 34, 69, 78, 3, 1'b1, 1890, 1'b1, 1'b1, 100);
      applyStimulus(0, 10, 10, 19, 19, 2, 1'b1, 100, 1'b1, 1'b0, -1);
      checkOutput("after reset done", 32'(doneO[0]), 1);
      checkOutput("after reset wr_count", wrO[0], 100);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
